i2c_txn_arbiter: RTL

- Shares one I2C master core between two requester ports.
- Each request is a single one-byte transaction: a 7-bit address, a read/write flag and, for writes, one data byte.
- The arbiter grants requests round-robin, issues a start pulse to the master, and retries transactions the subordinate NACKs.
- It detects a hung master with a timeout and returns read data plus a status code to the requester that was granted.

---
 rtl/i2c_txn_arbiter_if.sv | 50 +++++
 rtl/i2c_txn_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter_if.sv
// Bundle of requester-side and master-core-side signals around the I2C
// transaction arbiter. The arbiter uses the slave view; the requesters and
// the shared I2C master core together form the master view.
interface i2c_txn_arbiter_if;
  // requester port 0
  logic       req0;
  logic [6:0] addr0;
  logic       rw0;
  logic [7:0] wdata0;
  logic       done0;
  logic [7:0] rdata0;
  logic [1:0] err0;
  // requester port 1
  logic       req1;
  logic [6:0] addr1;
  logic       rw1;
  logic [7:0] wdata1;
  logic       done1;
  logic [7:0] rdata1;
  logic [1:0] err1;
  // shared status
  logic       busy;
  // I2C master core
  logic       m_start;
  logic [6:0] m_addr;
  logic       m_rw;
  logic [7:0] m_wdata;
  logic       m_busy;
  logic       m_done;
  logic       m_ack_error;
  logic [7:0] m_rdata;

  modport slave (
    input  req0, addr0, rw0, wdata0,
    input  req1, addr1, rw1, wdata1,
    input  m_busy, m_done, m_ack_error, m_rdata,
    output done0, rdata0, err0,
    output done1, rdata1, err1,
    output busy, m_start, m_addr, m_rw, m_wdata
  );

  modport master (
    output req0, addr0, rw0, wdata0,
    output req1, addr1, rw1, wdata1,
    output m_busy, m_done, m_ack_error, m_rdata,
    input  done0, rdata0, err0,
    input  done1, rdata1, err1,
    input  busy, m_start, m_addr, m_rw, m_wdata
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master core between two requesters.
// Each grant issues a one-cycle start, retries NACKed transfers up to
// MAX_RETRY times, aborts a hung master after TIMEOUT_CYCLES, and reports
// read data plus a status code to the granted port. Every output is a flop.
module i2c_txn_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRY      = 2,
  parameter int CNT_W          = 12
) (
  input  logic             clk_400,
  input  logic             rst_n,
  i2c_txn_arbiter_if.slave bus
);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [CNT_W-1:0] TC_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4,
    RESPOND   = 3'd5
  } state_t;

  state_t state_reg, state_next;

  logic             gnt_reg, gnt_next;
  logic             last_grant_reg, last_grant_next;
  logic [RW-1:0]    retry_reg, retry_next;
  logic [CNT_W-1:0] tcnt_reg, tcnt_next;
  logic             served0_reg, served0_next;
  logic             served1_reg, served1_next;

  logic             done0_reg, done0_next;
  logic             done1_reg, done1_next;
  logic [7:0]       rdata0_reg, rdata0_next;
  logic [7:0]       rdata1_reg, rdata1_next;
  logic [1:0]       err0_reg, err0_next;
  logic [1:0]       err1_reg, err1_next;
  logic             busy_reg, busy_next;
  logic             m_start_reg, m_start_next;
  logic [6:0]       m_addr_reg, m_addr_next;
  logic             m_rw_reg, m_rw_next;
  logic [7:0]       m_wdata_reg, m_wdata_next;

  // A port that already completed stays ineligible until it drops req.
  logic elig0, elig1, pick1, retry_ok, terminal;
  logic fin, fin_load;
  logic [1:0] fin_status;

  assign elig0    = bus.req0 & ~served0_reg;
  assign elig1    = bus.req1 & ~served1_reg;
  // Port 1 wins when it is alone, or when both compete and port 0 went last.
  assign pick1    = elig1 & (~elig0 | ~last_grant_reg);
  assign retry_ok = bus.m_ack_error & (retry_reg < RETRY_MAX);
  assign terminal = (tcnt_reg == TC_LAST);

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk_400 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      gnt_reg        <= 1'b0;
      last_grant_reg <= 1'b1;
      retry_reg      <= '0;
      tcnt_reg       <= '0;
      served0_reg    <= 1'b0;
      served1_reg    <= 1'b0;
      done0_reg      <= 1'b0;
      done1_reg      <= 1'b0;
      rdata0_reg     <= '0;
      rdata1_reg     <= '0;
      err0_reg       <= '0;
      err1_reg       <= '0;
      busy_reg       <= 1'b0;
      m_start_reg    <= 1'b0;
      m_addr_reg     <= '0;
      m_rw_reg       <= 1'b0;
      m_wdata_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      last_grant_reg <= last_grant_next;
      retry_reg      <= retry_next;
      tcnt_reg       <= tcnt_next;
      served0_reg    <= served0_next;
      served1_reg    <= served1_next;
      done0_reg      <= done0_next;
      done1_reg      <= done1_next;
      rdata0_reg     <= rdata0_next;
      rdata1_reg     <= rdata1_next;
      err0_reg       <= err0_next;
      err1_reg       <= err1_next;
      busy_reg       <= busy_next;
      m_start_reg    <= m_start_next;
      m_addr_reg     <= m_addr_next;
      m_rw_reg       <= m_rw_next;
      m_wdata_reg    <= m_wdata_next;
    end
  end

  // Next-state selection; m_done takes precedence over the terminal count.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (elig0 || elig1) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY,
      WAIT_DONE: begin
        if (bus.m_done)                         state_next = retry_ok ? GAP : RESPOND;
        else if (terminal)                      state_next = RESPOND;
        else if (bus.m_busy && state_reg == WAIT_BUSY) state_next = WAIT_DONE;
      end
      GAP:       if (!bus.m_busy) state_next = ISSUE;
      RESPOND:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping, decided one cycle
  // ahead so each output is asserted in the same cycle as its state.
  always_comb begin
    gnt_next        = gnt_reg;
    last_grant_next = last_grant_reg;
    retry_next      = retry_reg;
    tcnt_next       = tcnt_reg;
    done0_next      = 1'b0;
    done1_next      = 1'b0;
    rdata0_next     = rdata0_reg;
    rdata1_next     = rdata1_reg;
    err0_next       = err0_reg;
    err1_next       = err1_reg;
    busy_next       = busy_reg;
    m_start_next    = 1'b0;
    m_addr_next     = m_addr_reg;
    m_rw_next       = m_rw_reg;
    m_wdata_next    = m_wdata_reg;
    fin             = 1'b0;
    fin_load        = 1'b0;
    fin_status      = 2'b00;

    case (state_reg)
      IDLE: begin
        if (elig0 || elig1) begin
          gnt_next        = pick1;
          last_grant_next = pick1;
          busy_next       = 1'b1;
          retry_next      = '0;
          m_start_next    = 1'b1;
          m_addr_next     = pick1 ? bus.addr1  : bus.addr0;
          m_rw_next       = pick1 ? bus.rw1    : bus.rw0;
          m_wdata_next    = pick1 ? bus.wdata1 : bus.wdata0;
        end
      end
      ISSUE: tcnt_next = '0;
      WAIT_BUSY,
      WAIT_DONE: begin
        tcnt_next = tcnt_reg + CNT_W'(1);
        if (bus.m_done) begin
          if (retry_ok) begin
            retry_next = retry_reg + RW'(1);
          end else begin
            fin        = 1'b1;
            fin_status = bus.m_ack_error ? 2'b01 : 2'b00;
            fin_load   = ~bus.m_ack_error & m_rw_reg;
          end
        end else if (terminal) begin
          fin        = 1'b1;
          fin_status = 2'b10;
        end
      end
      GAP:     if (!bus.m_busy) m_start_next = 1'b1;
      RESPOND: busy_next = 1'b0;
      default: ;
    endcase

    if (fin) begin
      if (gnt_reg) begin
        done1_next = 1'b1;
        err1_next  = fin_status;
        if (fin_load) rdata1_next = bus.m_rdata;
      end else begin
        done0_next = 1'b1;
        err0_next  = fin_status;
        if (fin_load) rdata0_next = bus.m_rdata;
      end
    end

    served0_next = bus.req0 & (served0_reg | done0_next);
    served1_next = bus.req1 & (served1_reg | done1_next);
  end

  assign bus.done0   = done0_reg;
  assign bus.done1   = done1_reg;
  assign bus.rdata0  = rdata0_reg;
  assign bus.rdata1  = rdata1_reg;
  assign bus.err0    = err0_reg;
  assign bus.err1    = err1_reg;
  assign bus.busy    = busy_reg;
  assign bus.m_start = m_start_reg;
  assign bus.m_addr  = m_addr_reg;
  assign bus.m_rw    = m_rw_reg;
  assign bus.m_wdata = m_wdata_reg;
endmodule
